alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set operand/result width (legal 8..64, power of two).
REQ-002 Localparam SHW = clog2(WIDTH) SHALL set shift-amount width; not overridable.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; for shifts only B[SHW-1:0] SHALL be used as shift amount.
REQ-009 ALUOp  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRL, 111 SRA.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Result  output  WIDTH  registered result.
REQ-013 CarryOut, Zero, Overflow, Negative  output  1 each  registered flags.

Function
REQ-014 Transfer-in SHALL occur when in_valid && in_ready; A, B, ALUOp SHALL be captured only then.
REQ-015 Transfer-out SHALL occur when out_valid && out_ready; Result and flags SHALL stay stable while out_valid && !out_ready.
REQ-016 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1 (back-to-back), 0 in SHIFT and in DONE when out_ready=0.
REQ-018 Ops 000-100, and shifts with amount 0, SHALL go IDLE/DONE -> DONE with out_valid asserted the cycle after transfer-in (latency 1, throughput 1/cycle).
REQ-019 Shifts with amount n>0 SHALL go to SHIFT, shift one bit per cycle via down-counter, enter DONE after n cycles; out_valid the cycle after the last shift step (latency n+1).
REQ-020 DONE with transfer-out and no transfer-in SHALL go IDLE, out_valid 0 next cycle.
REQ-021 ADD SHALL compute A+B mod 2^WIDTH; SUB SHALL compute A+~B+1; CarryOut = MSB carry (SUB: 1 = no borrow).
REQ-022 Overflow SHALL be carry into MSB XOR carry out of MSB for ADD/SUB; 0 for all other ops.
REQ-023 SLT SHALL yield Result = {0..0, (A-B sign) XOR overflow}, signed compare; CarryOut = Overflow = 0.
REQ-024 SLL/SRL SHALL zero-fill; SRA SHALL replicate A[WIDTH-1]; CarryOut = Overflow = 0 for AND, OR, shifts.
REQ-025 Zero SHALL be 1 iff Result == 0; Negative SHALL equal Result[WIDTH-1]; both for every op.
REQ-026 in_valid during SHIFT SHALL be ignored (no capture, no corruption).
REQ-027 Unchanged inputs with in_ready=0 SHALL NOT be treated as a new request.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, out_valid 0, Result 0, all flags 0, shift counter 0, regardless of in-progress shift.
REQ-029 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Structure
REQ-030 Package alu_pkg SHALL hold ALUOp encodings and FSM state enumeration.
REQ-031 Combinational add/sub/logic/SLT datapath SHALL be sub-module alu_core (WIDTH-parametrised, outputs result, carry, overflow); FSM, shift register and handshake SHALL live in alu_mc.

Verification
REQ-032 WIDTH=16: ADD A=0x7FFF, B=0x0001 -> Result 0x8000, Overflow 1, Negative 1, CarryOut 0, Zero 0, out_valid 1 cycle after accept.
REQ-033 WIDTH=16: SUB A=0x0005, B=0x0005 -> Result 0x0000, Zero 1, CarryOut 1, Overflow 0; SLT A=0xFFFF, B=0x0001 -> Result 0x0001.
REQ-034 WIDTH=16: SRA A=0x8000, B=0x000F -> Result 0xFFFF after 16 cycles; in_ready 0 for 15 cycles; in_valid pulses during SHIFT ignored.
REQ-035 Back-to-back: ADD, OR, AND accepted on consecutive cycles with out_ready=1 -> three results on three consecutive cycles; then out_ready=0 for 3 cycles -> Result/flags held, in_ready 0.
REQ-036 reset_n low at shift cycle 4 of SLL A=0x0001, B=0x000A -> out_valid, Result, flags 0 immediately; after release, next ADD 2+3 -> Result 0x0005.
REQ-037 WIDTH=32: SLL A=0x00000001, B=0x0000001F -> Result 0x80000000, Negative 1, latency 32 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode and controller state encodings for alu_mc and alu_core.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_SLT = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_SRA = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(alu_op_e op);
      return op inside {OP_SLL, OP_SRL, OP_SRA};
   endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle logic/add/sub/SLT datapath; shift opcodes pass operand A through.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  alu_op_e          i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow
);

   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;
   logic             w_c_msb;
   logic             w_ovf;

   // SLT reuses the subtractor; overflow is carry-in vs carry-out of the MSB
   assign w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
   assign w_b_eff = w_sub ? ~i_b : i_b;
   assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + (WIDTH+1)'(w_sub);
   assign w_c_msb = i_a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
   assign w_ovf   = w_c_msb ^ w_sum[WIDTH];

   always_comb begin
      o_result   = i_a;
      o_carry    = 1'b0;
      o_overflow = 1'b0;
      case (i_op)
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_ADD, OP_SUB: begin
            o_result   = w_sum[WIDTH-1:0];
            o_carry    = w_sum[WIDTH];
            o_overflow = w_ovf;
         end
         OP_SLT: o_result = WIDTH'(w_sum[WIDTH-1] ^ w_ovf);
         default: o_result = i_a;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle ops through alu_core, shifts one bit per cycle,
// valid/ready handshake on both sides.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Zero,
   output logic             Overflow,
   output logic             Negative
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_e           r_state;
   state_e           w_state_nxt;
   alu_op_e          r_op;
   alu_op_e          w_op_in;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [SHW-1:0]   r_cnt;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;
   logic             r_carry;
   logic             r_zero;
   logic             r_ovf;
   logic             r_neg;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_xfer_out;
   logic             w_shift_now;
   logic             w_last_step;
   logic [WIDTH-1:0] w_core_result;
   logic             w_core_carry;
   logic             w_core_ovf;

   assign w_op_in     = alu_op_e'(ALUOp);
   assign w_shamt     = B[SHW-1:0];
   assign w_shift_now = is_shift(w_op_in) && (w_shamt != '0);
   assign w_last_step = (r_state == ST_SHIFT) && (r_cnt == SHW'(1));
   assign w_xfer_out  = r_out_valid && out_ready;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .i_a        (A),
      .i_b        (B),
      .i_op       (w_op_in),
      .o_result   (w_core_result),
      .o_carry    (w_core_carry),
      .o_overflow (w_core_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // DONE accepts a new request only when its own result leaves this cycle
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            w_accept   = in_valid;
            if (in_valid) w_state_nxt = w_shift_now ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            if (r_cnt == SHW'(1)) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_in_ready = out_ready;
            w_accept   = in_valid && out_ready;
            if (out_ready) begin
               if (in_valid) w_state_nxt = w_shift_now ? ST_SHIFT : ST_DONE;
               else          w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_shreg_nxt = r_shreg;
      case (r_op)
         OP_SLL:  w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
         OP_SRL:  w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
         default: w_shreg_nxt = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      endcase
   end

   // Result/flags change only on completion, so they hold while stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op        <= OP_AND;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_neg       <= 1'b0;
      end else if (w_accept) begin
         if (w_shift_now) begin
            r_op        <= w_op_in;
            r_shreg     <= A;
            r_cnt       <= w_shamt;
            r_out_valid <= 1'b0;
         end else begin
            r_result    <= w_core_result;
            r_carry     <= w_core_carry;
            r_ovf       <= w_core_ovf;
            r_zero      <= (w_core_result == '0);
            r_neg       <= w_core_result[WIDTH-1];
            r_out_valid <= 1'b1;
         end
      end else if (r_state == ST_SHIFT) begin
         r_shreg <= w_shreg_nxt;
         r_cnt   <= r_cnt - SHW'(1);
         if (w_last_step) begin
            r_result    <= w_shreg_nxt;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= (w_shreg_nxt == '0);
            r_neg       <= w_shreg_nxt[WIDTH-1];
            r_out_valid <= 1'b1;
         end
      end else if (w_xfer_out) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign Result    = r_result;
   assign CarryOut  = r_carry;
   assign Zero      = r_zero;
   assign Overflow  = r_ovf;
   assign Negative  = r_neg;

endmodule
